idex_stage: RTL and testbench

- ID/EX pipeline register with load-use hazard detection. It sits between decode and the forwarding unit / EX operand muxes.
- Captures decoded operand addresses, destination, write class and operand data each cycle.
- Presents idexOP1/idexOP2/idexregWrite registered to the forwarding unit.
- Inserts bubbles on load-use hazards and branch flushes. Freezes on downstream memory wait.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/load_use_detect.sv | 22 ++
 rtl/idex_stage.sv | 98 +++++++++
 tb/tb_idex_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, write-class encoding and the ID/EX bubble used by the pipeline stages.
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int RW_W   = 3;

    localparam logic [RW_W-1:0] RW_NONE = 3'b000;

    typedef struct packed {
        logic [REG_AW-1:0] op1;
        logic [REG_AW-1:0] op2;
        logic [REG_AW-1:0] dest;
        logic [RW_W-1:0]   regWrite;
        logic              memRead;
        logic              memW;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              valid;
    } idexBundle_t;

    localparam idexBundle_t IDEX_BUBBLE = '{
        op1:      '0,
        op2:      '0,
        dest:     '0,
        regWrite: RW_NONE,
        memRead:  1'b0,
        memW:     1'b0,
        a:        '0,
        b:        '0,
        valid:    1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in ID/EX and the instruction in decode.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic              idexValid,
    input  logic              idexMemRead,
    input  logic [REG_AW-1:0] idexDest,
    input  logic [REG_AW-1:0] idOP1,
    input  logic [REG_AW-1:0] idOP2,
    input  logic              idValid,
    output logic              hazard
);

    logic loadInFlight;
    logic srcMatch;

    // Register 0 is hardwired, so a load targeting it never produces a dependency.
    assign loadInFlight = idexValid && idexMemRead && (idexDest != '0);
    assign srcMatch     = (idexDest == idOP1) || (idexDest == idOP2);
    assign hazard       = loadInFlight && idValid && srcMatch;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory-wait freeze.
// Optional IDEX_STALL_STATS_EN adds a saturating stallCount of load-use stalls.
module idex_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] idOP1,
    input  logic [REG_AW-1:0] idOP2,
    input  logic [REG_AW-1:0] idDest,
    input  logic [RW_W-1:0]   idregWrite,
    input  logic              idMemRead,
    input  logic              idMemW,
    input  logic [DATA_W-1:0] idA,
    input  logic [DATA_W-1:0] idB,
    input  logic              idValid,
    input  logic              flush,
    input  logic              memHold,
    output logic [REG_AW-1:0] idexOP1,
    output logic [REG_AW-1:0] idexOP2,
    output logic [REG_AW-1:0] idexDest,
    output logic [RW_W-1:0]   idexregWrite,
    output logic              idexMemRead,
    output logic              idexMemW,
    output logic [DATA_W-1:0] idexA,
    output logic [DATA_W-1:0] idexB,
    output logic              idexValid,
    output logic              stall
`ifdef IDEX_STALL_STATS_EN
    ,
    output logic [15:0]       stallCount
`endif
);

    idexBundle_t stageQ;
    idexBundle_t idBundle;
    logic        hazard;
    logic        loadUseStall;

    load_use_detect uDetect (
        .idexValid   (stageQ.valid),
        .idexMemRead (stageQ.memRead),
        .idexDest    (stageQ.dest),
        .idOP1       (idOP1),
        .idOP2       (idOP2),
        .idValid     (idValid),
        .hazard      (hazard)
    );

    assign idBundle = '{
        op1:      idOP1,
        op2:      idOP2,
        dest:     idDest,
        regWrite: idregWrite,
        memRead:  idMemRead,
        memW:     idMemW,
        a:        idA,
        b:        idB,
        valid:    idValid
    };

    // A flush squashes the decode slot anyway, so it must not also hold the front end.
    assign loadUseStall = !rst && !memHold && !flush && hazard;
    assign stall        = !rst && (memHold || loadUseStall);

    always_ff @(posedge clk) begin
        if (rst) begin
            stageQ <= IDEX_BUBBLE;
        end else if (memHold) begin
            stageQ <= stageQ;
        end else if (flush || hazard || !idValid) begin
            stageQ <= IDEX_BUBBLE;
        end else begin
            stageQ <= idBundle;
        end
    end

`ifdef IDEX_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
        end else if (loadUseStall && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end
`endif

    assign idexOP1      = stageQ.op1;
    assign idexOP2      = stageQ.op2;
    assign idexDest     = stageQ.dest;
    assign idexregWrite = stageQ.regWrite;
    assign idexMemRead  = stageQ.memRead;
    assign idexMemW     = stageQ.memW;
    assign idexA        = stageQ.a;
    assign idexB        = stageQ.b;
    assign idexValid    = stageQ.valid;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed scenarios then randomized traffic against a cycle-level reference model.
module tb_idex_stage;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] idOP1, idOP2, idDest;
    logic [RW_W-1:0]   idregWrite;
    logic              idMemRead, idMemW, idValid, flush, memHold;
    logic [DATA_W-1:0] idA, idB;
    logic [REG_AW-1:0] idexOP1, idexOP2, idexDest;
    logic [RW_W-1:0]   idexregWrite;
    logic              idexMemRead, idexMemW, idexValid, stall;
    logic [DATA_W-1:0] idexA, idexB;
`ifdef IDEX_STALL_STATS_EN
    logic [15:0]       stallCount;
`endif

    always #5 clk = ~clk;

    idex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .idOP1        (idOP1),
        .idOP2        (idOP2),
        .idDest       (idDest),
        .idregWrite   (idregWrite),
        .idMemRead    (idMemRead),
        .idMemW       (idMemW),
        .idA          (idA),
        .idB          (idB),
        .idValid      (idValid),
        .flush        (flush),
        .memHold      (memHold),
        .idexOP1      (idexOP1),
        .idexOP2      (idexOP2),
        .idexDest     (idexDest),
        .idexregWrite (idexregWrite),
        .idexMemRead  (idexMemRead),
        .idexMemW     (idexMemW),
        .idexA        (idexA),
        .idexB        (idexB),
        .idexValid    (idexValid),
        .stall        (stall)
`ifdef IDEX_STALL_STATS_EN
        ,
        .stallCount   (stallCount)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: the instruction slot as a record; fields indexed 0..8 in port order.
    logic [31:0] mSlot [9];
    logic [15:0] mCnt;
    int          stallRun;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearSlot();
        for (int i = 0; i < 9; i++) mSlot[i] = 32'd0;
    endtask

    task automatic tick();
        logic haz;
        logic expStall;
        #1;
        // Decode reads a register the in-flight load has not produced yet.
        haz = (mSlot[8] == 1) && (mSlot[4] == 1) && (mSlot[2] != 0) && idValid &&
              ((mSlot[2] == 32'(idOP1)) || (mSlot[2] == 32'(idOP2)));
        if (rst)           expStall = 1'b0;
        else if (memHold)  expStall = 1'b1;
        else if (flush)    expStall = 1'b0;
        else               expStall = haz;
        chk("stall", 32'(stall), 32'(expStall));
        if (expStall && !memHold) stallRun++; else stallRun = 0;
        checks++;
        assert (stallRun <= 1) else begin
            errors++;
            $error("FAIL stallOneCycle observed=%0d expected<=1", stallRun);
        end
        @(posedge clk);
        if (rst) begin
            clearSlot();
            mCnt = 16'd0;
        end else if (!memHold) begin
            if (flush || haz || !idValid) clearSlot();
            else begin
                mSlot[0] = 32'(idOP1);  mSlot[1] = 32'(idOP2);  mSlot[2] = 32'(idDest);
                mSlot[3] = 32'(idregWrite); mSlot[4] = 32'(idMemRead); mSlot[5] = 32'(idMemW);
                mSlot[6] = 32'(idA);    mSlot[7] = 32'(idB);    mSlot[8] = 32'(idValid);
            end
            if (!flush && haz && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        end
        #1;
        chk("idexOP1", 32'(idexOP1), mSlot[0]);
        chk("idexOP2", 32'(idexOP2), mSlot[1]);
        chk("idexDest", 32'(idexDest), mSlot[2]);
        chk("idexregWrite", 32'(idexregWrite), mSlot[3]);
        chk("idexMemRead", 32'(idexMemRead), mSlot[4]);
        chk("idexMemW", 32'(idexMemW), mSlot[5]);
        chk("idexA", 32'(idexA), mSlot[6]);
        chk("idexB", 32'(idexB), mSlot[7]);
        chk("idexValid", 32'(idexValid), mSlot[8]);
`ifdef IDEX_STALL_STATS_EN
        chk("stallCount", 32'(stallCount), 32'(mCnt));
`endif
    endtask

    task automatic randId();
        idOP1      = REG_AW'($urandom_range(0, 5));
        idOP2      = REG_AW'($urandom_range(0, 5));
        idDest     = REG_AW'($urandom_range(0, 5));
        idregWrite = RW_W'($urandom_range(0, 7));
        idMemRead  = ($urandom_range(0, 99) < 45);
        idMemW     = ($urandom_range(0, 99) < 20);
        idA        = DATA_W'($urandom);
        idB        = DATA_W'($urandom);
        idValid    = ($urandom_range(0, 99) < 85);
    endtask

    initial begin
        clearSlot();
        mCnt = 16'd0;
        stallRun = 0;
        rst = 1'b1; flush = 1'b0; memHold = 1'b0;
        idOP1 = '0; idOP2 = '0; idDest = '0; idregWrite = RW_NONE;
        idMemRead = 1'b0; idMemW = 1'b0; idA = '0; idB = '0; idValid = 1'b0;
        tick();

        // Reset mid-run
        rst = 1'b0; idOP1 = 4'b0011; idregWrite = 3'b001; idValid = 1'b1;
        tick();
        chk("midLoadOP1", 32'(idexOP1), 32'h3);
        rst = 1'b1;
        tick();
        chk("rstValid", 32'(idexValid), 32'h0);
        chk("rstRegWrite", 32'(idexregWrite), 32'h0);
        rst = 1'b0;

        // Normal load
        idOP1 = 4'b0001; idOP2 = 4'b0010; idDest = 4'b0011; idregWrite = 3'b001;
        idA = 16'h1234; idB = 16'h5678; idMemRead = 1'b0; idMemW = 1'b0; idValid = 1'b1;
        tick();
        chk("normA", 32'(idexA), 32'h1234);
        chk("normDest", 32'(idexDest), 32'h3);

        // Load-use on operand 2
        idDest = 4'b0100; idMemRead = 1'b1;
        tick();
        idOP1 = 4'b0101; idOP2 = 4'b0100; idDest = 4'b0110; idMemRead = 1'b0; idA = 16'hBEEF;
        tick();
        chk("luBubbleValid", 32'(idexValid), 32'h0);
        chk("luBubbleRw", 32'(idexregWrite), 32'h0);
        tick();
        chk("luReplayDest", 32'(idexDest), 32'h6);
        chk("luReplayA", 32'(idexA), 32'hBEEF);

        // Flush beats hazard
        idDest = 4'b0100; idMemRead = 1'b1; idOP2 = 4'b0010;
        tick();
        idOP2 = 4'b0100; idMemRead = 1'b0; flush = 1'b1;
        tick();
        chk("flushValid", 32'(idexValid), 32'h0);
        flush = 1'b0;

        // memHold with changing decode inputs, then release
        idDest = 4'b0111; idA = 16'h0A0A; idMemRead = 1'b0;
        tick();
        memHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randId();
            tick();
            chk("holdA", 32'(idexA), 32'h0A0A);
        end
        memHold = 1'b0;
        randId();
        idValid = 1'b1;
        tick();

        // Randomized traffic, biased toward small register numbers and loads
        for (int i = 0; i < 600; i++) begin
            randId();
            rst     = ($urandom_range(0, 99) < 2);
            memHold = ($urandom_range(0, 99) < 15);
            flush   = ($urandom_range(0, 99) < 10);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
